// File: rtl/dm_jtag_pkg.sv
// Shared types for the JTAG debug transport module: TAP states, DMI opcodes,
// response/error codes, DMI access states and the dtmcs register layout.
package dm_jtag_pkg;

    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle,
        SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
        SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
    } tap_state_e;

    typedef enum logic [1:0] {
        DmiOpNop   = 2'd0,
        DmiOpRead  = 2'd1,
        DmiOpWrite = 2'd2,
        DmiOpRsvd  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DmiRespSuccess = 2'd0,
        DmiRespRsvd    = 2'd1,
        DmiRespErr     = 2'd2,
        DmiRespBusy    = 2'd3
    } dmi_resp_e;

    typedef enum logic [1:0] {
        DmiNoError  = 2'd0,
        DmiErrRsvd  = 2'd1,
        DmiOpFailed = 2'd2,
        DmiBusy     = 2'd3
    } dmi_error_e;

    typedef enum logic [2:0] {
        DmiIdle, DmiRead, DmiWaitRead, DmiWrite, DmiWaitWrite
    } dmi_state_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    // Anything other than success or busy is reported as a failed operation.
    function automatic dmi_error_e resp_to_error(input logic [1:0] resp);
        case (resp)
            DmiRespSuccess: return DmiNoError;
            DmiRespBusy:    return DmiBusy;
            default:        return DmiOpFailed;
        endcase
    endfunction

endpackage

// File: rtl/dmi_jtag_tap.sv
// IEEE 1149.1 TAP controller: 16-state FSM plus instruction register,
// exporting per-state strobes and the active instruction.
module dmi_jtag_tap
    import dm_jtag_pkg::*;
#(
    parameter int unsigned         IrLength = 5,
    parameter logic [IrLength-1:0] IrIdcode = 'h01
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                test_logic_reset,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                shift_ir,
    output logic [IrLength-1:0] ir,
    output logic                ir_tdo
);

    tap_state_e state, state_next;
    logic [IrLength-1:0] ir_shift;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= TestLogicReset;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TestLogicReset: state_next = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   state_next = tms_i ? SelectIrScan   : CaptureDr;
            CaptureDr:      state_next = tms_i ? Exit1Dr        : ShiftDr;
            ShiftDr:        state_next = tms_i ? Exit1Dr        : ShiftDr;
            Exit1Dr:        state_next = tms_i ? UpdateDr       : PauseDr;
            PauseDr:        state_next = tms_i ? Exit2Dr        : PauseDr;
            Exit2Dr:        state_next = tms_i ? UpdateDr       : ShiftDr;
            UpdateDr:       state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   state_next = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      state_next = tms_i ? Exit1Ir        : ShiftIr;
            ShiftIr:        state_next = tms_i ? Exit1Ir        : ShiftIr;
            Exit1Ir:        state_next = tms_i ? UpdateIr       : PauseIr;
            PauseIr:        state_next = tms_i ? Exit2Ir        : PauseIr;
            Exit2Ir:        state_next = tms_i ? UpdateIr       : ShiftIr;
            UpdateIr:       state_next = tms_i ? SelectDrScan   : RunTestIdle;
            default:        state_next = TestLogicReset;
        endcase
    end

    assign test_logic_reset = (state == TestLogicReset);
    assign capture_dr       = (state == CaptureDr);
    assign shift_dr         = (state == ShiftDr);
    assign update_dr        = (state == UpdateDr);
    assign shift_ir         = (state == ShiftIr);
    assign ir_tdo           = ir_shift[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir       <= IrIdcode;
            ir_shift <= '0;
        end else begin
            if (state == TestLogicReset) ir <= IrIdcode;
            else if (state == UpdateIr)  ir <= ir_shift;
            if (state == CaptureIr)      ir_shift <= IrLength'(1);
            else if (state == ShiftIr)   ir_shift <= {tdi_i, ir_shift[IrLength-1:1]};
        end
    end

endmodule

// File: rtl/dmi_jtag_dtm.sv
// RISC-V JTAG debug transport module: IDCODE/DTMCS/DMI/BYPASS data registers
// on top of the TAP, and the DMI request/response sequencer.
module dmi_jtag_dtm
    import dm_jtag_pkg::*;
#(
    parameter int unsigned         IrLength    = 5,
    parameter int unsigned         AddrWidth   = 7,
    parameter logic [31:0]         IdcodeValue = 32'h0000_0001,
    parameter logic [IrLength-1:0] IrIdcode    = 'h01,
    parameter logic [IrLength-1:0] IrDtmcs     = 'h10,
    parameter logic [IrLength-1:0] IrDmi       = 'h11,
    parameter int unsigned         IdleCycles  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 tdo_oe_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned DrWidth = AddrWidth + 34;

    logic                 tlr, cap_dr, sh_dr, upd_dr, sh_ir, ir_tdo;
    logic [IrLength-1:0]  ir;
    logic                 sel_idcode, sel_dtmcs, sel_dmi;
    logic [DrWidth-1:0]   dr_q, capture_val;
    dtmcs_t               dtmcs_cap;
    logic [1:0]           cap_op;
    logic [AddrWidth-1:0] address_q;
    logic [31:0]          data_q;
    dmi_error_e           error_q;
    dmi_state_e           state, state_next;
    logic                 dmi_access, dmi_reset, dmi_hardreset, busy_fire, resp_fire;

    dmi_jtag_tap #(
        .IrLength (IrLength),
        .IrIdcode (IrIdcode)
    ) u_tap (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tms_i            (tms_i),
        .tdi_i            (tdi_i),
        .test_logic_reset (tlr),
        .capture_dr       (cap_dr),
        .shift_dr         (sh_dr),
        .update_dr        (upd_dr),
        .shift_ir         (sh_ir),
        .ir               (ir),
        .ir_tdo           (ir_tdo)
    );

    assign sel_idcode = (ir == IrIdcode);
    assign sel_dtmcs  = (ir == IrDtmcs);
    assign sel_dmi    = (ir == IrDmi);

    assign dmi_access    = upd_dr && sel_dmi;
    assign dmi_reset     = upd_dr && sel_dtmcs && dr_q[16];
    assign dmi_hardreset = tlr || (upd_dr && sel_dtmcs && dr_q[17]);
    assign busy_fire     = (dmi_access && state != DmiIdle) ||
                           (cap_dr && sel_dmi && (state == DmiRead || state == DmiWaitRead));
    assign resp_fire     = dmi_resp_valid_i && (state == DmiWaitRead || state == DmiWaitWrite);

    // One shared shift register; each DR occupies its low bits and takes TDI at its own MSB.
    always_comb begin
        dtmcs_cap         = '0;
        dtmcs_cap.idle    = 3'(IdleCycles);
        dtmcs_cap.dmistat = error_q;
        dtmcs_cap.abits   = 6'(AddrWidth);
        dtmcs_cap.version = 4'd1;
        cap_op            = (error_q == DmiBusy || busy_fire) ? 2'd3 : error_q;
        capture_val       = '0;
        if (sel_idcode)     capture_val[31:0] = IdcodeValue;
        else if (sel_dtmcs) capture_val[31:0] = dtmcs_cap;
        else if (sel_dmi)   capture_val = {address_q, data_q, cap_op};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dr_q <= '0;
        end else if (cap_dr) begin
            dr_q <= capture_val;
        end else if (sh_dr) begin
            if (sel_dmi)                     dr_q <= {tdi_i, dr_q[DrWidth-1:1]};
            else if (sel_idcode || sel_dtmcs) dr_q[31:0] <= {tdi_i, dr_q[31:1]};
            else                             dr_q[0] <= tdi_i;
        end
    end

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else if (sh_ir) begin
            tdo_o    <= ir_tdo;
            tdo_oe_o <= 1'b1;
        end else if (sh_dr) begin
            tdo_o    <= dr_q[0];
            tdo_oe_o <= 1'b1;
        end else begin
            tdo_oe_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= DmiIdle;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        dmi_req_valid_o = 1'b0;
        dmi_req_op_o    = DmiOpNop;
        case (state)
            DmiIdle: begin
                if (dmi_access && error_q == DmiNoError) begin
                    if (dr_q[1:0] == DmiOpRead)       state_next = DmiRead;
                    else if (dr_q[1:0] == DmiOpWrite) state_next = DmiWrite;
                end
            end
            DmiRead: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = DmiOpRead;
                if (dmi_req_ready_i) state_next = DmiWaitRead;
            end
            DmiWrite: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = DmiOpWrite;
                if (dmi_req_ready_i) state_next = DmiWaitWrite;
            end
            DmiWaitRead, DmiWaitWrite: begin
                if (dmi_resp_valid_i) state_next = DmiIdle;
            end
            default: state_next = DmiIdle;
        endcase
        if (dmi_hardreset) state_next = DmiIdle;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            address_q <= '0;
            data_q    <= '0;
            error_q   <= DmiNoError;
        end else if (dmi_hardreset) begin
            address_q <= '0;
            data_q    <= '0;
            error_q   <= DmiNoError;
        end else begin
            if (state == DmiIdle && dmi_access && error_q == DmiNoError) begin
                address_q <= dr_q[DrWidth-1:34];
                data_q    <= dr_q[33:2];
            end
            if (state == DmiWaitRead && dmi_resp_valid_i && dmi_resp_resp_i == DmiRespSuccess)
                data_q <= dmi_resp_data_i;
            if (dmi_reset) begin
                error_q <= DmiNoError;
            end else if (error_q == DmiNoError) begin
                if (busy_fire)      error_q <= DmiBusy;
                else if (resp_fire) error_q <= resp_to_error(dmi_resp_resp_i);
            end
        end
    end

    assign dmi_req_addr_o   = address_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_resp_ready_o = 1'b1;

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Directed bench for dmi_jtag_dtm: JTAG scans checked through a result queue,
// and a DMI responder checking each request handshake against expected requests.
module tb_dmi_jtag_dtm;

    parameter int unsigned AW  = 7;
    parameter int unsigned IRL = 5;

    localparam int unsigned    DMI_W     = AW + 34;
    localparam logic [31:0]    IDCODE    = 32'h0000_0001;
    localparam logic [IRL-1:0] IR_IDCODE = IRL'('h01);
    localparam logic [IRL-1:0] IR_DTMCS  = IRL'('h10);
    localparam logic [IRL-1:0] IR_DMI    = IRL'('h11);
    localparam logic [IRL-1:0] IR_BYP    = '1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [1:0]    op;
    } req_t;

    logic          clk_i = 1'b0, rst_i, tms_i, tdi_i;
    logic          tdo_o, tdo_oe_o;
    logic          dmi_req_valid_o, dmi_req_ready_i;
    logic [AW-1:0] dmi_req_addr_o;
    logic [31:0]   dmi_req_data_o;
    logic [1:0]    dmi_req_op_o;
    logic          dmi_resp_valid_i, dmi_resp_ready_o;
    logic [31:0]   dmi_resp_data_i;
    logic [1:0]    dmi_resp_resp_i;

    dmi_jtag_dtm #(
        .IrLength    (IRL),
        .AddrWidth   (AW),
        .IdcodeValue (IDCODE),
        .IrIdcode    (IR_IDCODE),
        .IrDtmcs     (IR_DTMCS),
        .IrDmi       (IR_DMI),
        .IdleCycles  (1)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tms_i            (tms_i),
        .tdi_i            (tdi_i),
        .tdo_o            (tdo_o),
        .tdo_oe_o         (tdo_oe_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    req_t        req_q[$];

    int          ready_delay = 0;
    int          resp_delay  = 1;
    int          wait_cnt    = 0;
    int          resp_cnt    = 0;
    int          handshakes  = 0;
    logic [1:0]  resp_code   = 2'd0;
    logic [31:0] resp_data   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dtmcs_exp(input logic [1:0] stat);
        return {17'b0, 3'd1, stat, 6'(AW), 4'd1};
    endfunction

    function automatic logic [63:0] dmi_word(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [1:0] op);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        return (64'(a) << 34) | (64'(data) << 2) | 64'(op);
    endfunction

    task automatic push_req(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op);
        req_t r;
        r.addr = addr[AW-1:0];
        r.data = data;
        r.op   = op;
        req_q.push_back(r);
    endtask

    task automatic step(input logic tms, input logic tdi, output logic tdo_s, output logic oe_s);
        @(negedge clk_i);
        #1;
        tdo_s = tdo_o;
        oe_s  = tdo_oe_o;
        tms_i = tms;
        tdi_i = tdi;
        @(posedge clk_i);
    endtask

    task automatic move(input logic tms);
        logic t, o;
        step(tms, 1'b0, t, o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) move(1'b0);
    endtask

    // Scan from Run-Test/Idle back to Run-Test/Idle, LSB first.
    task automatic scan_chk(input string tag, input logic ir_sel, input logic [63:0] din,
                            input int n, input logic [63:0] expected);
        logic [63:0] dout;
        logic        oe_all, t, o;
        exp_q.push_back(expected);
        dout   = '0;
        oe_all = 1'b1;
        move(1'b1);
        if (ir_sel) move(1'b1);
        move(1'b0);
        move(1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], t, o);
            dout[i] = t;
            oe_all  = oe_all & o;
        end
        move(1'b1);
        move(1'b0);
        check(tag, dout, exp_q.pop_front());
        check({tag, ":oe"}, 64'(oe_all), 64'd1);
    endtask

    // DMI responder: grants after ready_delay cycles, answers resp_delay cycles later.
    initial begin
        req_t e;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i  = '0;
        dmi_resp_resp_i  = '0;
        forever begin
            @(negedge clk_i);
            #1;
            dmi_req_ready_i  = 1'b0;
            dmi_resp_valid_i = 1'b0;
            if (rst_i) begin
                wait_cnt = 0;
                resp_cnt = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dmi_resp_valid_i = 1'b1;
                    dmi_resp_resp_i  = resp_code;
                    dmi_resp_data_i  = resp_data;
                end
            end else if (dmi_req_valid_o) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt++;
                end else begin
                    dmi_req_ready_i = 1'b1;
                    wait_cnt        = 0;
                    handshakes++;
                    resp_cnt        = resp_delay;
                    check("req_pending", 64'(req_q.size()), 64'd1);
                    if (req_q.size() > 0) begin
                        e = req_q.pop_front();
                        check("req_addr", 64'(dmi_req_addr_o), 64'(e.addr));
                        check("req_data", 64'(dmi_req_data_o), 64'(e.data));
                        check("req_op",   64'(dmi_req_op_o),   64'(e.op));
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs0;
        logic t, o;
        rst_i = 1'b1;
        tms_i = 1'b1;
        tdi_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_tdo",   64'(tdo_o),            64'd0);
        check("rst_oe",    64'(tdo_oe_o),         64'd0);
        check("rst_valid", 64'(dmi_req_valid_o),  64'd0);
        check("rst_rrdy",  64'(dmi_resp_ready_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        move(1'b1);
        move(1'b0);

        scan_chk("idcode", 1'b0, 64'd0, 32, 64'(IDCODE));
        step(1'b0, 1'b0, t, o);
        check("rti_oe", 64'(o), 64'd0);
        scan_chk("ir_cap_dtmcs", 1'b1, 64'(IR_DTMCS), IRL, 64'd1);
        scan_chk("dtmcs", 1'b0, 64'd0, 32, 64'(dtmcs_exp(2'd0)));

        // Write with a one-cycle ready delay and successful response.
        scan_chk("ir_cap_dmi", 1'b1, 64'(IR_DMI), IRL, 64'd1);
        ready_delay = 1;
        resp_delay  = 1;
        resp_code   = 2'd0;
        hs0 = handshakes;
        push_req(32'h10, 32'hDEAD_BEEF, 2'd2);
        scan_chk("wr_issue", 1'b0, dmi_word(32'h10, 32'hDEAD_BEEF, 2'd2), DMI_W, 64'd0);
        idle(10);
        check("wr_handshakes", 64'(handshakes - hs0), 64'd1);
        check("wr_valid_low", 64'(dmi_req_valid_o), 64'd0);
        scan_chk("wr_result", 1'b0, 64'd0, DMI_W, dmi_word(32'h10, 32'hDEAD_BEEF, 2'd0));

        // Read answered three cycles after the handshake.
        ready_delay = 0;
        resp_delay  = 3;
        resp_data   = 32'h1234_5678;
        push_req(32'h11, 32'h0, 2'd1);
        scan_chk("rd_issue", 1'b0, dmi_word(32'h11, 0, 2'd1), DMI_W, 64'd0);
        idle(10);
        scan_chk("rd_result", 1'b0, 64'd0, DMI_W, dmi_word(32'h11, 32'h1234_5678, 2'd0));

        // Capture while the read is outstanding reports busy, which sticks.
        resp_delay = 40;
        resp_data  = 32'hCAFE_F00D;
        push_req(32'h11, 32'h0, 2'd1);
        scan_chk("busy_issue", 1'b0, dmi_word(32'h11, 0, 2'd1), DMI_W, 64'd0);
        scan_chk("busy_cap", 1'b0, 64'd0, DMI_W, dmi_word(32'h11, 32'h0, 2'd3));
        idle(20);
        scan_chk("busy_sticky", 1'b0, 64'd0, DMI_W, dmi_word(32'h11, 32'hCAFE_F00D, 2'd3));
        scan_chk("ir_dtmcs2", 1'b1, 64'(IR_DTMCS), IRL, 64'd1);
        scan_chk("busy_dmistat", 1'b0, 64'h0001_0000, 32, 64'(dtmcs_exp(2'd3)));
        scan_chk("dmireset_clr", 1'b0, 64'd0, 32, 64'(dtmcs_exp(2'd0)));

        // Error response, then hardreset with dmireset also set.
        scan_chk("ir_dmi2", 1'b1, 64'(IR_DMI), IRL, 64'd1);
        resp_delay = 1;
        resp_code  = 2'd2;
        push_req(32'h12, 32'h55, 2'd2);
        scan_chk("err_issue", 1'b0, dmi_word(32'h12, 32'h55, 2'd2), DMI_W,
                 dmi_word(32'h11, 32'hCAFE_F00D, 2'd0));
        idle(10);
        resp_code = 2'd0;
        scan_chk("ir_dtmcs3", 1'b1, 64'(IR_DTMCS), IRL, 64'd1);
        scan_chk("err_dmistat", 1'b0, 64'h0003_0000, 32, 64'(dtmcs_exp(2'd2)));
        scan_chk("hard_clr", 1'b0, 64'd0, 32, 64'(dtmcs_exp(2'd0)));
        scan_chk("ir_dmi3", 1'b1, 64'(IR_DMI), IRL, 64'd1);
        scan_chk("hard_regs", 1'b0, 64'd0, DMI_W, 64'd0);

        // Hardreset while waiting for a read response; late response is dropped.
        resp_delay = 150;
        resp_data  = 32'hBAD0_BAD0;
        push_req(32'h13, 32'h0, 2'd1);
        scan_chk("hwait_issue", 1'b0, dmi_word(32'h13, 0, 2'd1), DMI_W, 64'd0);
        idle(3);
        scan_chk("ir_dtmcs4", 1'b1, 64'(IR_DTMCS), IRL, 64'd1);
        scan_chk("hwait_hard", 1'b0, 64'h0002_0000, 32, 64'(dtmcs_exp(2'd0)));
        #1;
        check("hwait_valid", 64'(dmi_req_valid_o), 64'd0);
        scan_chk("ir_dmi4", 1'b1, 64'(IR_DMI), IRL, 64'd1);
        idle(150);
        scan_chk("hwait_discard", 1'b0, 64'd0, DMI_W, 64'd0);

        // Hardreset while a request is still waiting for ready.
        ready_delay = 1000;
        resp_delay  = 1;
        scan_chk("hreq_issue", 1'b0, dmi_word(32'h14, 0, 2'd1), DMI_W, 64'd0);
        #1;
        check("hreq_valid", 64'(dmi_req_valid_o), 64'd1);
        check("hreq_addr",  64'(dmi_req_addr_o),  64'h14);
        check("hreq_op",    64'(dmi_req_op_o),    64'd1);
        scan_chk("ir_dtmcs5", 1'b1, 64'(IR_DTMCS), IRL, 64'd1);
        scan_chk("hreq_hard", 1'b0, 64'h0002_0000, 32, 64'(dtmcs_exp(2'd0)));
        #1;
        check("hreq_drop", 64'(dmi_req_valid_o), 64'd0);
        ready_delay = 0;

        // BYPASS delays TDI by one cycle after a captured zero.
        scan_chk("ir_byp", 1'b1, 64'(IR_BYP), IRL, 64'd1);
        scan_chk("bypass", 1'b0, 64'hA5, 8, 64'h4A);

        // Five TMS=1 from Pause-DR reach Test-Logic-Reset and restore IDCODE.
        scan_chk("ir_dmi5", 1'b1, 64'(IR_DMI), IRL, 64'd1);
        move(1'b1);
        move(1'b0);
        move(1'b1);
        move(1'b0);
        repeat (5) move(1'b1);
        move(1'b0);
        scan_chk("tlr_idcode", 1'b0, 64'd0, 32, 64'(IDCODE));
        check("req_queue_empty", 64'(req_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmi_jtag_dtm.md
DMI_JTAG_DTM -- requirements
Module: dmi_jtag_dtm

Interface
REQ-001 Param IrLength, default 5, instruction register width (>=2).
REQ-002 Param AddrWidth, default 7, DMI address width; reported in dtmcs.abits.
REQ-003 Param IdcodeValue, default 32'h0000_0001, IDCODE DR content (bit0 SHALL be 1).
REQ-004 Param IrIdcode / IrDtmcs / IrDmi, defaults 'h01 / 'h10 / 'h11, IR opcodes; all other codes, including all-ones, select BYPASS.
REQ-005 Param IdleCycles, default 1, 3-bit value reported in dtmcs.idle.
REQ-006 clk_i  in  1  JTAG TCK; all state except tdo_o/tdo_oe_o on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 tms_i  in  1  test mode select; tdi_i  in  1  test data in.
REQ-009 tdo_o  out  1  test data out; tdo_oe_o  out  1  TDO drive enable.
REQ-010 dmi_req_valid_o  out  1; dmi_req_ready_i  in  1; dmi_req_addr_o  out  AddrWidth; dmi_req_data_o  out  32; dmi_req_op_o  out  2 (1 read, 2 write).
REQ-011 dmi_resp_valid_i  in  1; dmi_resp_ready_o  out  1 (constant 1); dmi_resp_data_i  in  32; dmi_resp_resp_i  in  2 (0 success, 2 err, 3 busy).

Function
REQ-012 TAP FSM SHALL implement all 16 IEEE 1149.1 states and transitions exactly, including Pause-IR -> Exit2-IR on tms=1, Pause-IR on tms=0.
REQ-013 Five consecutive tms=1 cycles SHALL reach Test-Logic-Reset from any state.
REQ-014 Capture-IR loads IR shift reg with ...0001 (LSBs 01, rest 0); Shift-IR shifts tdi_i in at MSB; Update-IR copies to IR.
REQ-015 Test-Logic-Reset SHALL set IR to IrIdcode.
REQ-016 Capture-DR: IDCODE loads IdcodeValue; BYPASS loads 1'b0 (1-bit DR); DTMCS loads {14'b0, hardreset 0, dmireset 0, 1'b0, IdleCycles, dmistat=error_q, abits=AddrWidth, version=4'd1}; DMI loads {address_q, data_q, op} with op = 3 if error_q==busy or a busy condition fires that cycle, else error_q.
REQ-017 Shift-DR shifts the selected DR right, tdi_i into its MSB; DMI DR width AddrWidth+34.
REQ-018 tdo_o and tdo_oe_o SHALL update on falling clk_i edge: in Shift-IR/Shift-DR, tdo_o = LSB of active shift reg, tdo_oe_o = 1; otherwise tdo_oe_o = 0, tdo_o holds.
REQ-019 DMI FSM states Idle, Read, WaitRead, Write, WaitWrite.
REQ-020 Idle: Update-DR with DMI selected and error_q==0 latches address/data; op 1 -> Read, op 2 -> Write, op 0/3 -> stay (nop).
REQ-021 Read/Write: dmi_req_valid_o=1 with stable addr/data/op until dmi_req_ready_i; then WaitRead/WaitWrite.
REQ-022 WaitRead on resp valid: success -> data_q=resp data; err -> op-failed; busy -> busy; -> Idle. WaitWrite: same error mapping, data unchanged, -> Idle.
REQ-023 Busy condition: Update-DR (DMI) while FSM not Idle, or Capture-DR (DMI) in Read/WaitRead.
REQ-024 error_q sticky: set to 3 (busy) or 2 (op failed) only when currently 0; busy wins when both fire same cycle.
REQ-025 Update-DR with DTMCS selected and dmireset=1 SHALL clear error_q only; FSM unaffected.
REQ-026 Update-DR with DTMCS selected and dmihardreset=1, or Test-Logic-Reset, SHALL force FSM Idle, error_q=0, address_q/data_q=0, drop dmi_req_valid_o next cycle; in-flight response discarded.
REQ-027 dmireset and dmihardreset both set: hardreset behaviour.

Reset
REQ-028 rst_i SHALL asynchronously set TAP to Test-Logic-Reset, IR=IrIdcode, all DRs 0, DMI FSM Idle, error_q=0, address/data 0, dmi_req_valid_o=0, tdo_o=0, tdo_oe_o=0.

Structure
REQ-029 dtmcs_t, DMI op/resp enums, dmi error enum, TAP state enum SHALL live in shared package dm_jtag_pkg.
REQ-030 TAP controller (FSM + IR) SHALL be sub-module dmi_jtag_tap, parametrised by IrLength and IrIdcode, exporting state strobes and IR.
REQ-031 No latches; every output driven in every state.

Verification
REQ-032 Reset, Shift-DR 32 cycles -> tdo_o = 32'h0000_0001 LSB first; IR capture shifts out ...00001.
REQ-033 IR=IrDtmcs, scan -> tdo yields 0x0000_1071 (idle 1, abits 7, version 1, dmistat 0).
REQ-034 DMI write addr 0x10 data 0xDEAD_BEEF, ready 1 cycle later, resp success -> single valid/ready handshake, op=2, next DMI capture op=0.
REQ-035 DMI read addr 0x11, resp data 0x1234_5678 after 3 cycles, scan -> 0x1234_5678 op=0; capture before resp -> op=3, sticky until dmireset via DTMCS.
REQ-036 Resp err -> dmistat=2; hardreset mid-WaitRead -> Idle, valid low, error 0; IR=0x1F -> 1-cycle BYPASS delay on tdo.
REQ-037 AddrWidth=9, IrLength=8 build: abits=9, DMI DR 43 bits, all above scenarios pass.
